posit_mult_pipe: RTL and testbench

POSIT_MULT_PIPE -- requirements
Module: posit_mult_pipe

---
 rtl/posit_mult_pipe.sv | 132 +++++++++++++
 tb/tb_posit_mult_pipe.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_mult_pipe.sv
// Two-stage pipelined posit product core: multiplies decoded posit operands
// (sign/inf/zero/scale/fraction) and presents a normalized product with valid/ready flow control.
module posit_mult_pipe #(
  parameter int unsigned POSIT_WIDTH = 8,
  parameter int unsigned POSIT_ES    = 0,
  localparam int unsigned SW  = $clog2(POSIT_WIDTH - 1) + POSIT_ES + 1,
  localparam int unsigned FW  = POSIT_WIDTH - 3 - POSIT_ES,
  localparam int unsigned PSW = SW + 1,
  localparam int unsigned PFW = 2 * (FW + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic           a_sign,
  input  logic           a_inf,
  input  logic           a_zero,
  input  logic [SW-1:0]  a_scale,
  input  logic [FW-1:0]  a_fraction,
  input  logic           b_sign,
  input  logic           b_inf,
  input  logic           b_zero,
  input  logic [SW-1:0]  b_scale,
  input  logic [FW-1:0]  b_fraction,
  output logic           m_valid,
  input  logic           m_ready,
  output logic           p_sign,
  output logic           p_inf,
  output logic           p_zero,
  output logic [PSW-1:0] p_scale,
  output logic [PFW-1:0] p_fraction
);

  logic           rdy1_c;
  logic           rdy2_c;

  logic           s1_v_q;
  logic           s1_sign_q, s1_inf_q, s1_zero_q;
  logic [PSW-1:0] s1_sum_q;
  logic [PFW-1:0] s1_mant_q;

  logic           s1_sign_d, s1_inf_d, s1_zero_d;
  logic [PSW-1:0] s1_sum_d;
  logic [PFW-1:0] s1_mant_d;

  logic           s2_v_q;
  logic           p_sign_q, p_inf_q, p_zero_q;
  logic [PSW-1:0] p_scale_q;
  logic [PFW-1:0] p_fraction_q;

  logic           p_sign_d, p_inf_d, p_zero_d;
  logic [PSW-1:0] p_scale_d;
  logic [PFW-1:0] p_fraction_d;

  // A stage may advance when it is empty or the stage after it is advancing.
  assign rdy2_c  = ~s2_v_q | m_ready;
  assign rdy1_c  = ~s1_v_q | rdy2_c;
  assign s_ready = rdy1_c;

  // Stage 1: combine flags, add scales, multiply mantissas with hidden ones restored.
  always_comb begin
    s1_sign_d = a_sign ^ b_sign;
    s1_inf_d  = a_inf | b_inf;
    s1_zero_d = (a_zero | b_zero) & ~s1_inf_d;
    s1_sum_d  = PSW'($signed(a_scale)) + PSW'($signed(b_scale));
    s1_mant_d = PFW'({1'b1, a_fraction}) * PFW'({1'b1, b_fraction});
  end

  // Stage 2: product of two [1,2) mantissas lies in [1,4); shift so the leading one sits at the MSB.
  always_comb begin
    p_sign_d     = s1_sign_q;
    p_inf_d      = s1_inf_q;
    p_zero_d     = s1_zero_q;
    p_scale_d    = s1_sum_q;
    p_fraction_d = s1_mant_q << 1;
    if (s1_mant_q[PFW-1]) begin
      p_scale_d    = s1_sum_q + PSW'(1);
      p_fraction_d = s1_mant_q;
    end
    if (s1_inf_q || s1_zero_q) begin
      p_sign_d     = 1'b0;
      p_scale_d    = '0;
      p_fraction_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q       <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_inf_q     <= 1'b0;
      s1_zero_q    <= 1'b0;
      s1_sum_q     <= '0;
      s1_mant_q    <= '0;
      s2_v_q       <= 1'b0;
      p_sign_q     <= 1'b0;
      p_inf_q      <= 1'b0;
      p_zero_q     <= 1'b0;
      p_scale_q    <= '0;
      p_fraction_q <= '0;
    end else begin
      if (rdy1_c) begin
        s1_v_q <= s_valid;
        if (s_valid) begin
          s1_sign_q <= s1_sign_d;
          s1_inf_q  <= s1_inf_d;
          s1_zero_q <= s1_zero_d;
          s1_sum_q  <= s1_sum_d;
          s1_mant_q <= s1_mant_d;
        end
      end
      if (rdy2_c) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          p_sign_q     <= p_sign_d;
          p_inf_q      <= p_inf_d;
          p_zero_q     <= p_zero_d;
          p_scale_q    <= p_scale_d;
          p_fraction_q <= p_fraction_d;
        end
      end
    end
  end

  assign m_valid    = s2_v_q;
  assign p_sign     = p_sign_q;
  assign p_inf      = p_inf_q;
  assign p_zero     = p_zero_q;
  assign p_scale    = p_scale_q;
  assign p_fraction = p_fraction_q;

endmodule

// File: tb/tb_posit_mult_pipe.sv
// Bench for posit_mult_pipe: directed products, flow control, reset behaviour and a
// random posit stream scored against a real-valued posit product model.
module tb_posit_mult_pipe;

  localparam int unsigned SW  = 4;
  localparam int unsigned FW  = 5;
  localparam int unsigned PSW = 5;
  localparam int unsigned PFW = 12;

  typedef struct packed {
    logic          sign;
    logic          inf;
    logic          zero;
    logic [SW-1:0] scale;
    logic [FW-1:0] frac;
  } op_t;

  typedef struct packed {
    logic           sign;
    logic           inf;
    logic           zero;
    logic [PSW-1:0] scale;
    logic [PFW-1:0] frac;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic s_valid = 1'b0;
  logic s_ready;
  logic a_sign = 1'b0, a_inf = 1'b0, a_zero = 1'b0;
  logic [SW-1:0] a_scale = '0;
  logic [FW-1:0] a_fraction = '0;
  logic b_sign = 1'b0, b_inf = 1'b0, b_zero = 1'b0;
  logic [SW-1:0] b_scale = '0;
  logic [FW-1:0] b_fraction = '0;
  logic m_valid;
  logic m_ready = 1'b0;
  logic p_sign, p_inf, p_zero;
  logic [PSW-1:0] p_scale;
  logic [PFW-1:0] p_fraction;

  int total = 0;
  int bad   = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  posit_mult_pipe #(.POSIT_WIDTH(8), .POSIT_ES(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready),
    .a_sign(a_sign), .a_inf(a_inf), .a_zero(a_zero), .a_scale(a_scale), .a_fraction(a_fraction),
    .b_sign(b_sign), .b_inf(b_inf), .b_zero(b_zero), .b_scale(b_scale), .b_fraction(b_fraction),
    .m_valid(m_valid), .m_ready(m_ready),
    .p_sign(p_sign), .p_inf(p_inf), .p_zero(p_zero), .p_scale(p_scale), .p_fraction(p_fraction)
  );

  // Decode an 8-bit, es=0 posit into sign / regime-scale / left-aligned fraction.
  function automatic op_t decode(input logic [7:0] p);
    op_t o;
    logic [7:0] v;
    logic [6:0] bits;
    logic first;
    int i, run, k, fv;
    o = '0;
    if (p == 8'h00) begin
      o.zero = 1'b1;
    end else if (p == 8'h80) begin
      o.inf = 1'b1;
    end else begin
      o.sign = p[7];
      v = p[7] ? 8'(-p) : p;
      bits = v[6:0];
      first = bits[6];
      run = 0;
      i = 6;
      while (i >= 0 && bits[3'(i)] == first) begin
        run++;
        i--;
      end
      k = first ? run - 1 : -run;
      o.scale = SW'(k);
      if (i > 0) begin
        fv = int'(bits) & ((1 << i) - 1);
        o.frac = FW'(fv << (5 - i));
      end
    end
    return o;
  endfunction

  // Product computed as a real number, then renormalized into [1,2) with a scale count.
  function automatic res_t ref_mul(input op_t a, input op_t b);
    res_t r;
    real mr;
    int e;
    r = '0;
    r.inf  = a.inf | b.inf;
    r.zero = (a.zero | b.zero) & ~r.inf;
    if (!(r.inf || r.zero)) begin
      r.sign = a.sign ^ b.sign;
      mr = (1.0 + real'(int'(a.frac)) / 32.0) * (1.0 + real'(int'(b.frac)) / 32.0);
      e = int'($signed(a.scale)) + int'($signed(b.scale));
      while (mr >= 2.0) begin
        mr = mr / 2.0;
        e++;
      end
      r.scale = PSW'(e);
      r.frac  = PFW'($rtoi(mr * 2048.0));
    end
    return r;
  endfunction

  function automatic res_t observed();
    return {p_sign, p_inf, p_zero, p_scale, p_fraction};
  endfunction

  task automatic drive_ops(input op_t a, input op_t b);
    a_sign = a.sign; a_inf = a.inf; a_zero = a.zero; a_scale = a.scale; a_fraction = a.frac;
    b_sign = b.sign; b_inf = b.inf; b_zero = b.zero; b_scale = b.scale; b_fraction = b.frac;
  endtask

  task automatic test_reset();
    s_valid = 1'b1;
    m_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
    total++;
    if (observed() !== res_t'(0)) begin bad++; $display("FAIL reset_outputs got=%h want=0", observed()); end
    total++;
    if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%b want=1", s_ready); end
    @(negedge clk);
    s_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    op_t  ca[6];
    op_t  cb[6];
    res_t ce[6];
    ca[0] = {3'b000, 4'd0, 5'b10000};      cb[0] = {3'b000, 4'd0, 5'b10000};
    ce[0] = {3'b000, 5'd1, 12'b100100000000};
    ca[1] = {3'b000, 4'd0, 5'b00000};      cb[1] = {3'b100, 4'd0, 5'b00000};
    ce[1] = {3'b100, 5'd0, 12'b100000000000};
    ca[2] = {3'b000, 4'b1010, 5'b00000};   cb[2] = {3'b000, 4'b1010, 5'b00000};
    ce[2] = {3'b000, 5'b10100, 12'b100000000000};
    ca[3] = {3'b110, 4'b0101, 5'b10101};   cb[3] = {3'b001, 4'b0011, 5'b01110};
    ce[3] = {3'b010, 5'd0, 12'd0};
    ca[4] = {3'b001, 4'b0010, 5'b00111};   cb[4] = {3'b100, 4'b1100, 5'b11000};
    ce[4] = {3'b001, 5'd0, 12'd0};
    ca[5] = {3'b000, 4'b0110, 5'b11111};   cb[5] = {3'b000, 4'b0110, 5'b11111};
    ce[5] = {3'b000, 5'b01101, 12'hF81};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive_ops(ca[c], cb[c]);
      s_valid = 1'b1;
      m_ready = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      #1;
      total++;
      if (m_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_early_valid got=%b want=0", c, m_valid); end
      @(negedge clk);
      #1;
      total++;
      if (m_valid !== 1'b1) begin bad++; $display("FAIL dir%0d_latency got=%b want=1", c, m_valid); end
      total++;
      if (observed() !== ce[c]) begin bad++; $display("FAIL dir%0d_value got=%h want=%h", c, observed(), ce[c]); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int outs;
    op_t a, b;
    outs = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 22; cyc++) begin
      @(negedge clk);
      m_ready = 1'b1;
      s_valid = (cyc < 20);
      a = decode(8'($urandom));
      b = decode(8'($urandom));
      drive_ops(a, b);
      #1;
      if (m_valid) begin
        outs++;
        total++;
        if (exp_q.size() == 0 || observed() !== exp_q[0]) begin
          bad++; $display("FAIL b2b_value cyc=%0d got=%h queued=%0d", cyc, observed(), exp_q.size());
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (s_valid && s_ready) exp_q.push_back(ref_mul(a, b));
    end
    total++;
    if (outs != 20) begin bad++; $display("FAIL b2b_throughput got=%0d want=20", outs); end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int sent, cyc;
    logic saw_full, prev_stall;
    res_t prev_obs;
    op_t a, b;
    sent = 0; saw_full = 1'b0; prev_stall = 1'b0; prev_obs = '0;
    exp_q.delete();
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      m_ready = !(cyc >= 3 && cyc <= 6);
      s_valid = (sent < 5);
      a = decode(8'($urandom));
      b = decode(8'($urandom));
      drive_ops(a, b);
      #1;
      total++;
      if (s_ready !== !(exp_q.size() == 2 && !m_ready)) begin
        bad++; $display("FAIL bp_s_ready cyc=%0d got=%b", cyc, s_ready);
      end
      if (!s_ready) saw_full = 1'b1;
      if (prev_stall) begin
        total++;
        if (m_valid !== 1'b1 || observed() !== prev_obs) begin
          bad++; $display("FAIL bp_hold cyc=%0d got=%h want=%h", cyc, observed(), prev_obs);
        end
      end
      if (m_valid) begin
        total++;
        if (exp_q.size() == 0 || observed() !== exp_q[0]) begin
          bad++; $display("FAIL bp_order cyc=%0d got=%h queued=%0d", cyc, observed(), exp_q.size());
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_obs = observed();
      if (m_valid && m_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (s_valid && s_ready) begin
        exp_q.push_back(ref_mul(a, b));
        sent++;
      end
      if (sent == 5 && exp_q.size() == 0) break;
    end
    total++;
    if (!saw_full) begin bad++; $display("FAIL bp_stall_seen got=0 want=1"); end
    total++;
    if (sent != 5 || exp_q.size() != 0) begin
      bad++; $display("FAIL bp_drain sent=%0d left=%0d want=5/0", sent, exp_q.size());
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic test_random_stream();
    localparam int N = 4096;
    int sent;
    logic done;
    op_t a, b;
    sent = 0;
    done = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 40000 && !done; cyc++) begin
      @(negedge clk);
      s_valid = (sent < N) && ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      a = decode(8'(sent / 16));
      b = decode(8'($urandom));
      drive_ops(a, b);
      #1;
      total++;
      if (s_ready !== !(exp_q.size() == 2 && !m_ready)) begin
        bad++; $display("FAIL rnd_s_ready cyc=%0d got=%b queued=%0d", cyc, s_ready, exp_q.size());
      end
      if (m_valid) begin
        total++;
        if (exp_q.size() == 0 || observed() !== exp_q[0]) begin
          bad++; $display("FAIL rnd_value cyc=%0d got=%h want=%h", cyc, observed(),
                          (exp_q.size() != 0) ? exp_q[0] : res_t'(0));
        end
        if (m_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (s_valid && s_ready) begin
        exp_q.push_back(ref_mul(a, b));
        sent++;
      end
      if (sent == N && exp_q.size() == 0) done = 1'b1;
    end
    total++;
    if (!done) begin bad++; $display("FAIL rnd_timeout sent=%0d left=%0d", sent, exp_q.size()); end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    logic full;
    full = 1'b0;
    for (int cyc = 0; cyc < 10 && !full; cyc++) begin
      @(negedge clk);
      s_valid = 1'b1;
      m_ready = 1'b0;
      drive_ops(decode(8'($urandom)), decode(8'h40));
      #1;
      if (!s_ready) full = 1'b1;
    end
    total++;
    if (!full || m_valid !== 1'b1) begin bad++; $display("FAIL mid_fill full=%b m_valid=%b want=1/1", full, m_valid); end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid got=%b want=0", m_valid); end
    total++;
    if (observed() !== res_t'(0)) begin bad++; $display("FAIL mid_reset_outputs got=%h want=0", observed()); end
    total++;
    if (s_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_s_ready got=%b want=1", s_ready); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      #1;
      total++;
      if (m_valid !== 1'b0) begin bad++; $display("FAIL mid_stale cyc=%0d got=%b want=0", cyc, m_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random_stream();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
